sram_data_port: RTL
===================

# sram_data_port

Multi-cycle data-memory access unit for the MEM stage of the 16-bit pipeline CPU. It sits between the EX/MEM pipeline register and MEM/WB and drives the external asynchronous SRAM (ram1) through a registered control FSM. It holds the pipeline with `stall` while an access is in flight and returns load data on `dataOut`.

## Interface
Parameters:
- `ADDR_W`, 16: width of the address bus and of `ram1Addr`.
- `DATA_W`, 16: width of the data path and of `ram1Data`.
- `READ_CYCLES`, 2: number of cycles `ram1OE` stays low before read data is captured. Minimum 1.
- `WE_CYCLES`, 1: width of the `ram1WE` low pulse, in cycles. Minimum 1.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `memRead`  in  1: load request from EX/MEM.
- `memWrite`  in  1: store request from EX/MEM.
- `address`  in  ADDR_W: access address (the ALU result).
- `dataIn`  in  DATA_W: store data.
- `dataOut`  out  DATA_W: last loaded word, registered.
- `stall`  out  1: pipeline hold.
- `ram1OE`  out  1: SRAM output enable, active-low, registered.
- `ram1WE`  out  1: SRAM write enable, active-low, registered.
- `ram1EN`  out  1: SRAM chip enable, active-low, registered.
- `ram1Addr`  out  ADDR_W: SRAM address, registered.
- `ram1Data`  inout  DATA_W: SRAM data bus; high-Z except in the write states.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Requests are sampled only in IDLE. Upstream holds `memRead`, `memWrite`, `address` and `dataIn` stable while `stall`=1.
- Transitions out of IDLE:
  - `memWrite`=1 → WR_SETUP. Write has priority: if both requests are high, only the write is performed.
  - `memRead`=1 only → RD.
  - Neither → stay in IDLE.
  - On leaving IDLE, latch `address` into `ram1Addr` and `dataIn` into the write buffer.
- RD:
  - `ram1EN`=0, `ram1OE`=0, bus released.
  - Counter runs from READ_CYCLES-1 down to 0. At 0, capture `ram1Data` into `dataOut` and go to DONE.
- WR_SETUP (1 cycle): `ram1EN`=0, `ram1WE`=1, bus driven with the buffer. Next state WR_PULSE.
- WR_PULSE (WE_CYCLES cycles): `ram1WE`=0, bus driven. Then WR_HOLD.
- WR_HOLD (1 cycle): `ram1WE`=1, bus still driven. Then DONE.
- DONE (1 cycle): all controls inactive (`ram1EN`=`ram1OE`=`ram1WE`=1), bus Z, `stall`=0. Next state IDLE.
- `stall` is combinational: `(IDLE && (memRead||memWrite)) || (state ∉ {IDLE, DONE})`.
- `dataOut` changes only on read capture or reset. Writes leave it unchanged.
- `ram1Data` may be driven only in WR_SETUP, WR_PULSE and WR_HOLD. `ram1OE` and `ram1WE` are never low in the same cycle.

## Timing
- Reset values: state IDLE, `dataOut`=0, `ram1Addr`=0, `ram1OE`=`ram1WE`=`ram1EN`=1, bus Z, `stall`=0 (with no request).
- Read latency: 1 + READ_CYCLES cycles of stall, then DONE. With default parameters, a request seen at cycle 0 gives `stall` high in cycles 0–2 and valid `dataOut` from cycle 3.
- Write occupancy: 1 + 1 + WE_CYCLES + 1 stall cycles, then DONE (4 with defaults).
- Data setup and hold around the WE pulse are each at least one full cycle. Address is stable from WR_SETUP through WR_HOLD.
- Pipeline advances on the DONE edge. A new request may be accepted in the IDLE cycle immediately after DONE, so back-to-back accesses are separated by exactly one DONE cycle.
- `RST` asserted in any state: on the next edge, state goes to IDLE, `ram1WE`/`ram1OE`/`ram1EN` go to 1, the bus is released and `dataOut` is cleared. An aborted write may leave the SRAM word undefined; no retry is attempted.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum `mem_state_t`;
  - the defaults for `ADDR_W` and `DATA_W`;
  - `RAM_ACTIVE`=1'b0 for the active-low strobe level.
- Single module; no sub-module. The counter and tristate driver are inline.

## Test plan
- Idle, no request for 10 cycles → `stall`=0, all strobes 1, bus Z, `dataOut`=0.
- Read at 0x1234, SRAM model holds 0xBEEF → `stall` high 3 cycles, `ram1OE` low exactly 2 cycles, `dataOut`=0xBEEF in the DONE cycle and held afterwards.
- Write 0x00A5 to 0x0010 → `ram1WE` low exactly 1 cycle, bus = 0x00A5 one cycle before and one after the pulse, model word 0x0010 = 0x00A5, `dataOut` unchanged.
- Write 0x5A5A to 0x0020, then read 0x0020 back-to-back → one DONE/IDLE gap between the accesses, `dataOut`=0x5A5A.
- `memRead`=`memWrite`=1, `dataIn`=0x1111 → write performed only, `ram1OE` never low, `dataOut` keeps its previous value.
- `RST` asserted during WR_PULSE → next edge: `ram1WE`=1, bus Z, state IDLE, `stall`=0, `dataOut`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM data port.
// Strobes on the ram1 bus are active-low; RAM_ACTIVE names that level.
package mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_DONE
   } mem_state_t;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   localparam logic RAM_ACTIVE = 1'b0;

endpackage

// File: rtl/sram_data_port_if.sv
// Pipeline-side request/response bundle between EX/MEM and the SRAM data port.
// master = pipeline (issues loads/stores), slave = the data port.
interface sram_data_port_if #(
   parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
   parameter int DATA_W = mem_pkg::DATA_W_DEF
) ();

   logic              memRead;
   logic              memWrite;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] dataIn;
   logic [DATA_W-1:0] dataOut;
   logic              stall;

   modport master (
      output memRead, memWrite, address, dataIn,
      input  dataOut, stall
   );

   modport slave (
      input  memRead, memWrite, address, dataIn,
      output dataOut, stall
   );

endinterface

// File: rtl/sram_data_port.sv
// MEM-stage access unit for the external async SRAM (ram1): a registered
// control FSM that sequences reads and setup/pulse/hold writes and stalls the pipe.
module sram_data_port
   import mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int READ_CYCLES = 2,
   parameter int WE_CYCLES   = 1
) (
   input  logic              CLK,
   input  logic              RST,
   sram_data_port_if.slave   pipe,
   output logic              ram1OE,
   output logic              ram1WE,
   output logic              ram1EN,
   output logic [ADDR_W-1:0] ram1Addr,
   inout  wire  [DATA_W-1:0] ram1Data
);

   localparam int CNT_MAX = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   mem_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wbuf_q, wbuf_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              en_q, en_d;
   logic              bus_drv;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      dout_d  = dout_q;
      oe_d    = ~RAM_ACTIVE;
      we_d    = ~RAM_ACTIVE;
      en_d    = ~RAM_ACTIVE;

      unique case (state_q)
         S_IDLE: begin
            // write wins when both requests are raised together
            if (pipe.memWrite) begin
               state_d = S_WR_SETUP;
               addr_d  = pipe.address;
               wbuf_d  = pipe.dataIn;
            end else if (pipe.memRead) begin
               state_d = S_RD;
               cnt_d   = CNT_W'(READ_CYCLES - 1);
               addr_d  = pipe.address;
               wbuf_d  = pipe.dataIn;
            end
         end
         S_RD: begin
            if (cnt_q == '0) begin
               dout_d  = ram1Data;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WR_SETUP: begin
            state_d = S_WR_PULSE;
            cnt_d   = CNT_W'(WE_CYCLES - 1);
         end
         S_WR_PULSE: begin
            if (cnt_q == '0) state_d = S_WR_HOLD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_WR_HOLD: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // strobes are decoded from the next state so they register glitch-free
      case (state_d)
         S_RD: begin
            en_d = RAM_ACTIVE;
            oe_d = RAM_ACTIVE;
         end
         S_WR_SETUP, S_WR_HOLD: en_d = RAM_ACTIVE;
         S_WR_PULSE: begin
            en_d = RAM_ACTIVE;
            we_d = RAM_ACTIVE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         dout_q  <= '0;
         oe_q    <= ~RAM_ACTIVE;
         we_q    <= ~RAM_ACTIVE;
         en_q    <= ~RAM_ACTIVE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         en_q    <= en_d;
      end
   end

   assign bus_drv  = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                     (state_q == S_WR_HOLD);
   assign ram1Data = bus_drv ? wbuf_q : {DATA_W{1'bz}};

   assign ram1OE   = oe_q;
   assign ram1WE   = we_q;
   assign ram1EN   = en_q;
   assign ram1Addr = addr_q;

   assign pipe.dataOut = dout_q;
   assign pipe.stall   = ((state_q == S_IDLE) && (pipe.memRead || pipe.memWrite)) ||
                         ((state_q != S_IDLE) && (state_q != S_DONE));

endmodule
